instr_block_memory: RTL and testbench

INSTR_BLOCK_MEMORY -- requirements
Module: instr_block_memory

---
 rtl/instr_mem_pkg.sv | 18 +
 rtl/instr_mem_array.sv | 30 +++
 rtl/instr_block_memory.sv | 82 ++++++++
 tb/tb_instr_block_memory.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared widths, default latency and FSM encoding for the block-fetch instruction memory.
package instr_mem_pkg;

    localparam int BLOCK_W              = 128;
    localparam int BLOCK_ADDR_W         = 6;
    localparam int WORD_ADDR_W          = 8;
    localparam int WORD_W               = 32;
    localparam int NUM_BLOCKS           = 1 << BLOCK_ADDR_W;
    localparam int COUNT_W              = 8;
    localparam int DEFAULT_READ_LATENCY = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/instr_mem_array.sv
// 64 x 128-bit instruction storage: word-granular preload writes, whole-block asynchronous read.
module instr_mem_array
    import instr_mem_pkg::*;
(
    input  logic                    clock,
    input  logic                    write_en,
    input  logic [WORD_ADDR_W-1:0]  write_addr,
    input  logic [WORD_W-1:0]       write_data,
    input  logic [BLOCK_ADDR_W-1:0] read_addr,
    output logic [BLOCK_W-1:0]      read_data
);

    logic [BLOCK_W-1:0]      mem [NUM_BLOCKS];
    logic [BLOCK_ADDR_W-1:0] write_block;
    logic [6:0]              write_lsb;

    assign write_block = write_addr[WORD_ADDR_W-1:2];
    assign write_lsb   = {write_addr[1:0], 5'b00000};

    // NOTE: the storage has no reset on purpose -- preloaded program contents must survive a reset,
    // and leaving it unreset lets synthesis map it onto RAM.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_block][write_lsb +: WORD_W] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/instr_block_memory.sv
// Block-fetch instruction memory: IDLE/BUSY/DONE handshake with a fixed latency of READ_LATENCY busy cycles.
module instr_block_memory
    import instr_mem_pkg::*;
#(
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         mem_read,
    input  logic [5:0]   mem_address,
    output logic [127:0] mem_readdata,
    output logic         mem_busywait,
    input  logic         load_en,
    input  logic [7:0]   load_addr,
    input  logic [31:0]  load_data
);

    localparam logic [COUNT_W-1:0] COUNT_START = COUNT_W'(READ_LATENCY - 1);

    state_t                  state;
    logic [COUNT_W-1:0]      count;
    logic [BLOCK_ADDR_W-1:0] addr_q;
    logic [BLOCK_W-1:0]      block_data;
    logic                    write_en;

    // Preload only touches the array while no fetch is pending or being requested.
    assign write_en = load_en && !reset && (state == IDLE) && !mem_read;

    instr_mem_array u_array (
        .clock      (clock),
        .write_en   (write_en),
        .write_addr (load_addr),
        .write_data (load_data),
        .read_addr  (addr_q),
        .read_data  (block_data)
    );

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        mem_busywait = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    mem_busywait = mem_read;
                BUSY:    mem_busywait = 1'b1;
                default: mem_busywait = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            addr_q       <= '0;
            mem_readdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read) begin
                        addr_q <= mem_address;
                        count  <= COUNT_START;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (!mem_read) begin
                        state <= IDLE;
                    end else if (count == '0) begin
                        mem_readdata <= block_data;
                        state        <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_block_memory.sv
// Randomized scoreboard bench for instr_block_memory against a word-array reference model.
module tb_instr_block_memory;
    import instr_mem_pkg::*;

    localparam int LAT = 5;

    logic         clock = 1'b0;
    logic         reset;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    logic         load_en;
    logic [7:0]   load_addr;
    logic [31:0]  load_data;

    always #5 clock = ~clock;

    instr_block_memory #(.READ_LATENCY(LAT)) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data)
    );

    int           n_vectors     = 0;
    int           n_miscompares = 0;
    logic [31:0]  words [256];
    logic [127:0] exp_q [$];
    logic [127:0] last_data = '0;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [127:0] block_of(input int b);
        return {words[4*b+3], words[4*b+2], words[4*b+1], words[4*b]};
    endfunction

    // Monitor: a fetch completes when busywait falls while the request was still held.
    int   run        = 0;
    logic prev_busy  = 1'b0;
    logic prev_read  = 1'b0;
    logic prev_reset = 1'b1;
    logic [127:0] exp_data;

    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (!reset && !prev_reset && prev_read && prev_busy && !mem_busywait) begin
                if (exp_q.size() == 0) begin
                    check("unexpected completion", 128'(1), 128'(0));
                end else begin
                    exp_data = exp_q.pop_front();
                    check("fetch data", mem_readdata, exp_data);
                    check("busywait cycles", 128'(run), 128'(LAT + 1));
                    last_data = exp_data;
                end
            end
            if (mem_read && mem_busywait && !reset) run++;
            else run = 0;
            prev_busy  = mem_busywait;
            prev_read  = mem_read;
            prev_reset = reset;
        end
    end

    task automatic write_word(input int a, input logic [31:0] d);
        @(negedge clock);
        load_en   = 1'b1;
        load_addr = 8'(a);
        load_data = d;
        words[a]  = d;
    endtask

    // Called at a negedge; returns at the negedge of the cycle in which busywait fell.
    task automatic fetch(input int blk, input bit keep_read, input bit jitter, input int alt_addr, input bit bad_load);
        bit done = 1'b0;
        mem_address = 6'(blk);
        mem_read    = 1'b1;
        exp_q.push_back(block_of(blk));
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (!mem_busywait) begin
                done = 1'b1;
                break;
            end
            if (jitter && i >= 1) mem_address = 6'($urandom_range(0, 63));
            if (alt_addr >= 0 && i == 1) mem_address = 6'(alt_addr);
            if (bad_load && i == 1) begin
                load_en   = 1'b1;
                load_addr = 8'h0C;
                load_data = 32'hDEADBEEF;
            end else begin
                load_en = 1'b0;
            end
        end
        if (!done) check("fetch timeout", 128'(0), 128'(1));
        load_en = 1'b0;
        if (!keep_read) mem_read = 1'b0;
    endtask

    initial begin
        int nwrites;
        int next_gap;
        reset       = 1'b1;
        mem_read    = 1'b1;
        mem_address = '0;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        @(negedge clock);
        #1 check("busywait during reset", 128'(mem_busywait), 128'(0));
        repeat (2) @(negedge clock);
        mem_read = 1'b0;
        reset    = 1'b0;
        #1;
        check("readdata after reset", mem_readdata, 128'(0));
        check("busywait idle", 128'(mem_busywait), 128'(0));

        for (int a = 0; a < 256; a++) write_word(a, $urandom);
        write_word(12, 32'h11111111);
        write_word(13, 32'h22222222);
        write_word(14, 32'h33333333);
        write_word(15, 32'h44444444);
        @(negedge clock);
        load_en = 1'b0;

        // Load during reset must be ignored.
        reset = 1'b1;
        load_en = 1'b1; load_addr = 8'h0C; load_data = 32'hBAADF00D;
        @(negedge clock);
        reset = 1'b0;
        load_en = 1'b0;

        check("model block 3", block_of(3), 128'h44444444_33333333_22222222_11111111);
        fetch(3, 1'b0, 1'b0, -1, 1'b0);
        @(negedge clock);
        fetch(3, 1'b0, 1'b0, 7, 1'b0);
        @(negedge clock);

        // Abort: mem_read low at E2 of a fetch of block 7.
        mem_address = 6'd7;
        mem_read = 1'b1;
        @(negedge clock);
        @(negedge clock);
        mem_read = 1'b0;
        @(negedge clock);
        #1;
        check("busywait after abort", 128'(mem_busywait), 128'(0));
        check("readdata after abort", mem_readdata, last_data);

        // Reset at E3 of a fetch of block 3.
        mem_address = 6'd3;
        mem_read = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1 check("busywait in reset mid-fetch", 128'(mem_busywait), 128'(0));
        @(negedge clock);
        reset = 1'b0;
        mem_read = 1'b0;
        #1;
        check("readdata after mid-fetch reset", mem_readdata, 128'(0));
        check("busywait after mid-fetch reset", 128'(mem_busywait), 128'(0));
        last_data = '0;
        fetch(3, 1'b0, 1'b0, -1, 1'b0);
        @(negedge clock);

        fetch(3, 1'b0, 1'b0, -1, 1'b1);
        @(negedge clock);
        fetch(3, 1'b1, 1'b0, -1, 1'b0);
        fetch(0, 1'b0, 1'b0, -1, 1'b0);
        @(negedge clock);

        for (int k = 0; k < 40; k++) begin
            next_gap = int'($urandom_range(0, 2));
            fetch(int'($urandom_range(0, 63)), next_gap == 0, 1'b1, -1, $urandom_range(0, 3) == 0);
            if (next_gap > 0) begin
                @(negedge clock);
                nwrites = int'($urandom_range(0, 3));
                for (int j = 0; j < nwrites; j++) write_word(int'($urandom_range(0, 255)), $urandom);
                @(negedge clock);
                load_en = 1'b0;
            end
        end

        repeat (3) @(negedge clock);
        check("scoreboard drained", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
